// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared state encoding and default constants for the program
// counter / fetch-request generator and its pending-redirect buffer.
package pc_gen_pkg;

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        ISSUE   = 2'd1,
        STALLED = 2'd2
    } pc_state_e;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
    localparam int          INCR_DEFAULT         = 4;

    function automatic logic is_word_aligned(input logic [1:0] low_bits);
        return (low_bits == 2'b00);
    endfunction

endpackage

// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch-request handshake between the PC generator (master)
// and the instruction fetch stage (slave).
interface pc_gen_if #(
    parameter int XLEN = 32
);

    logic            fetch_valid;
    logic            fetch_ready;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] pc_plus_incr;

    modport master (
        output fetch_valid,
        output fetch_pc,
        output pc_plus_incr,
        input  fetch_ready
    );

    modport slave (
        input  fetch_valid,
        input  fetch_pc,
        input  pc_plus_incr,
        output fetch_ready
    );

endinterface

// File: rtl/pc_redirect_buf.sv
// pc_redirect_buf: one-entry holding register for a redirect that arrives
// while a fetch request is still waiting to be accepted. A trap always
// overwrites the entry; a branch redirect never displaces a pending trap.
module pc_redirect_buf #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear_i,
    input  logic            capture_i,
    input  logic            trap_valid_i,
    input  logic [XLEN-1:0] trap_target_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_target_i,
    output logic            pending_valid_o,
    output logic [XLEN-1:0] pending_target_o
);

    logic            valid_q,   valid_d;
    logic            is_trap_q, is_trap_d;
    logic [XLEN-1:0] target_q,  target_d;

    // Decide the next entry contents: clearing wins, then a trap, then a redirect that may not displace a trap.
    always_comb begin
        valid_d   = valid_q;
        is_trap_d = is_trap_q;
        target_d  = target_q;
        if (clear_i) begin
            valid_d   = 1'b0;
            is_trap_d = 1'b0;
            target_d  = '0;
        end else if (capture_i) begin
            if (trap_valid_i) begin
                valid_d   = 1'b1;
                is_trap_d = 1'b1;
                target_d  = trap_target_i;
            end else if (redirect_valid_i && !(valid_q && is_trap_q)) begin
                valid_d   = 1'b1;
                is_trap_d = 1'b0;
                target_d  = redirect_target_i;
            end
        end
    end

    // Entry register, emptied asynchronously on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= 1'b0;
            is_trap_q <= 1'b0;
            target_q  <= '0;
        end else begin
            valid_q   <= valid_d;
            is_trap_q <= is_trap_d;
            target_q  <= target_d;
        end
    end

    assign pending_valid_o  = valid_q;
    assign pending_target_o = target_q;

endmodule

// File: rtl/pc_gen.sv
// pc_gen: program counter and fetch-request generator. Issues the PC over a
// valid/ready handshake, steps by INCR, and takes trap/branch redirects with
// trap priority, parking one redirect while a request awaits acceptance.
// Optional build macro PC_ALIGN_CHECK_EN: rejects misaligned branch targets
// (pulsing misalign_o) and forces trap vectors to word alignment.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT),
    parameter int              INCR         = INCR_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_target_i,
    input  logic            trap_valid_i,
    input  logic [XLEN-1:0] trap_vector_i,
    pc_gen_if.master        fetch_if,
`ifdef PC_ALIGN_CHECK_EN
    output logic            misalign_o,
`endif
    output logic            redirect_pending_o
);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_plus_incr;
    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] trap_tgt;
    logic            redir_ok;
    logic            fetch_valid;
    logic            transfer;
    logic            pend_clear;
    logic            pend_capture;
    logic            pend_valid;
    logic [XLEN-1:0] pend_target;

`ifdef PC_ALIGN_CHECK_EN
    logic misalign_q, misalign_d;

    assign redir_ok   = redirect_valid_i && is_word_aligned(redirect_target_i[1:0]);
    assign misalign_d = redirect_valid_i && !is_word_aligned(redirect_target_i[1:0]);
    assign trap_tgt   = trap_vector_i & ~XLEN'(3);

    // Misalign flag is a one-cycle echo of a rejected branch target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign misalign_o = misalign_q;
`else
    assign redir_ok = redirect_valid_i;
    assign trap_tgt = trap_vector_i;
`endif

    assign pc_plus_incr = pc_q + XLEN'(INCR);
    assign fetch_valid  = (state_q == ISSUE);
    assign transfer     = fetch_valid && fetch_if.fetch_ready;

    assign next_pc = trap_valid_i ? trap_tgt          :
                     redir_ok     ? redirect_target_i :
                     pend_valid   ? pend_target       :
                                    pc_plus_incr;

    // Next state and PC: redirects land directly outside ISSUE, and inside ISSUE the PC only moves on a transfer.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_clear   = 1'b0;
        pend_capture = 1'b0;
        case (state_q)
            BOOT, STALLED: begin
                if (trap_valid_i || redir_ok) begin
                    pc_d       = trap_valid_i ? trap_tgt : redirect_target_i;
                    pend_clear = 1'b1;
                end
                state_d = stall_i ? STALLED : ISSUE;
            end
            ISSUE: begin
                if (transfer) begin
                    pc_d       = next_pc;
                    pend_clear = 1'b1;
                    state_d    = stall_i ? STALLED : ISSUE;
                end else begin
                    pend_capture = 1'b1;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // State and PC registers; reset drops any outstanding request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_VECTOR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    pc_redirect_buf #(
        .XLEN (XLEN)
    ) u_redirect_buf (
        .clk               (clk),
        .rst               (rst),
        .clear_i           (pend_clear),
        .capture_i         (pend_capture),
        .trap_valid_i      (trap_valid_i),
        .trap_target_i     (trap_tgt),
        .redirect_valid_i  (redir_ok),
        .redirect_target_i (redirect_target_i),
        .pending_valid_o   (pend_valid),
        .pending_target_o  (pend_target)
    );

    assign fetch_if.fetch_valid  = fetch_valid;
    assign fetch_if.fetch_pc     = pc_q;
    assign fetch_if.pc_plus_incr = pc_plus_incr;
    assign redirect_pending_o    = pend_valid;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed bench for pc_gen. Stimulus pushes the fetch addresses
// it expects to see accepted into a queue; an independent monitor pops and
// compares on every accepted request. Direct checks cover reset, hold,
// stall and pending-flag behaviour.
module tb_pc_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        redirectValid;
   logic [31:0] redirectTarget;
   logic        trapValid;
   logic [31:0] trapVector;
   logic        redirectPending;
`ifdef PC_ALIGN_CHECK_EN
   logic        misalign;
`endif

   int          compared   = 0;
   int          mismatched = 0;
   logic [31:0] expQ[$];
   logic [31:0] monExp;

   pc_gen_if #(.XLEN(32)) fetchIf ();

   pc_gen #(
      .XLEN         (32),
      .RESET_VECTOR (32'h0000_0000),
      .INCR         (4)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .stall_i            (stall),
      .redirect_valid_i   (redirectValid),
      .redirect_target_i  (redirectTarget),
      .trap_valid_i       (trapValid),
      .trap_vector_i      (trapVector),
      .fetch_if           (fetchIf),
`ifdef PC_ALIGN_CHECK_EN
      .misalign_o         (misalign),
`endif
      .redirect_pending_o (redirectPending)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Monitor: every accepted request must match the oldest expected address.
   always @(negedge clk) begin
      if (!rst && fetchIf.fetch_valid && fetchIf.fetch_ready) begin
         compared++;
         if (expQ.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL transfer: got fetch_pc=0x%08h, expected no transfer", fetchIf.fetch_pc);
         end else begin
            monExp = expQ.pop_front();
            if (fetchIf.fetch_pc !== monExp) begin
               mismatched++;
               $display("[TB] FAIL transfer: got fetch_pc=0x%08h, expected 0x%08h", fetchIf.fetch_pc, monExp);
            end
         end
      end
   end

   // Drive one cycle of inputs; strobes drop again afterwards.
   task automatic applyStimulus(input logic st, input logic rv, input logic [31:0] rt,
                                input logic tv, input logic [31:0] tt, input logic rdy);
      stall               = st;
      redirectValid       = rv;
      redirectTarget      = rt;
      trapValid           = tv;
      trapVector          = tt;
      fetchIf.fetch_ready = rdy;
      @(posedge clk);
      #1;
      redirectValid = 1'b0;
      trapValid     = 1'b0;
   endtask

   // Direct comparison against a hand-computed value.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Run cycles until the DUT presents the given address, bounded.
   task automatic waitForPc(input logic [31:0] target);
      bit found = 1'b0;
      for (int n = 0; n < 64 && !found; n++) begin
         @(posedge clk);
         #1;
         if (fetchIf.fetch_valid && fetchIf.fetch_pc == target) found = 1'b1;
      end
      compared++;
      if (!found) begin
         mismatched++;
         $display("[TB] FAIL reach_pc: got fetch_pc=0x%08h, expected 0x%08h within 64 cycles", fetchIf.fetch_pc, target);
      end
   endtask

   initial begin
      rst                 = 1'b1;
      stall               = 1'b0;
      redirectValid       = 1'b0;
      redirectTarget      = 32'h0;
      trapValid           = 1'b0;
      trapVector          = 32'h0;
      fetchIf.fetch_ready = 1'b1;

      // Reset values, then one BOOT cycle with no request.
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset fetch_valid", 32'(fetchIf.fetch_valid), 32'h0);
      checkOutput("reset fetch_pc", fetchIf.fetch_pc, 32'h0);
      checkOutput("reset pending", 32'(redirectPending), 32'h0);
      checkOutput("reset pc_plus_incr", fetchIf.pc_plus_incr, 32'h4);
      rst = 1'b0;
      checkOutput("boot fetch_valid", 32'(fetchIf.fetch_valid), 32'h0);

      // Sequential stream from the reset vector.
      expQ.push_back(32'h0);
      expQ.push_back(32'h4);
      expQ.push_back(32'h8);
      expQ.push_back(32'hC);
      waitForPc(32'h10);

      // Fetch stage not ready for three cycles: request must hold.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
         checkOutput("hold fetch_valid", 32'(fetchIf.fetch_valid), 32'h1);
         checkOutput("hold fetch_pc", fetchIf.fetch_pc, 32'h10);
      end
      expQ.push_back(32'h10);
      expQ.push_back(32'h14);
      expQ.push_back(32'h18);
      expQ.push_back(32'h1C);
      fetchIf.fetch_ready = 1'b1;
      waitForPc(32'h20);

      // Redirect then trap while waiting; a later redirect must not displace the trap.
      applyStimulus(1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
      checkOutput("pending after redirect", 32'(redirectPending), 32'h1);
      checkOutput("pc held while pending", fetchIf.fetch_pc, 32'h20);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h800, 1'b0);
      applyStimulus(1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
      checkOutput("pending after trap", 32'(redirectPending), 32'h1);
      expQ.push_back(32'h20);
      expQ.push_back(32'h800);
      expQ.push_back(32'h804);
      fetchIf.fetch_ready = 1'b1;
      waitForPc(32'h808);
      checkOutput("pending cleared", 32'(redirectPending), 32'h0);

      // Same-cycle trap and redirect with a transfer: trap wins.
      expQ.push_back(32'h808);
      applyStimulus(1'b0, 1'b1, 32'h100, 1'b1, 32'h800, 1'b1);
      checkOutput("trap beats redirect", fetchIf.fetch_pc, 32'h800);
      expQ.push_back(32'h800);
      waitForPc(32'h804);

      // Steer to 0x3C, then stall right after the 0x40 transfer.
      expQ.push_back(32'h804);
      applyStimulus(1'b0, 1'b1, 32'h3C, 1'b0, 32'h0, 1'b1);
      expQ.push_back(32'h3C);
      waitForPc(32'h40);
      expQ.push_back(32'h40);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      checkOutput("stalled fetch_valid", 32'(fetchIf.fetch_valid), 32'h0);
      applyStimulus(1'b1, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1);
      checkOutput("stalled redirect pc", fetchIf.fetch_pc, 32'h200);
      checkOutput("stalled redirect no pending", 32'(redirectPending), 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      checkOutput("still stalled fetch_valid", 32'(fetchIf.fetch_valid), 32'h0);
      expQ.push_back(32'h200);
      expQ.push_back(32'h204);
      stall = 1'b0;
      waitForPc(32'h208);

      // Wrap-around at the top of the address space.
      expQ.push_back(32'h208);
      applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1);
      checkOutput("top pc", fetchIf.fetch_pc, 32'hFFFF_FFFC);
      checkOutput("wrap pc_plus_incr", fetchIf.pc_plus_incr, 32'h0);
      expQ.push_back(32'hFFFF_FFFC);
      expQ.push_back(32'h0);
      waitForPc(32'h4);

      // Misaligned branch target.
      expQ.push_back(32'h4);
      applyStimulus(1'b0, 1'b1, 32'h102, 1'b0, 32'h0, 1'b1);
`ifdef PC_ALIGN_CHECK_EN
      checkOutput("misalign pulse", 32'(misalign), 32'h1);
      checkOutput("misaligned target ignored", fetchIf.fetch_pc, 32'h8);
      expQ.push_back(32'h8);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      checkOutput("misalign one cycle", 32'(misalign), 32'h0);
      expQ.push_back(32'hC);
      waitForPc(32'h10);
      expQ.push_back(32'h10);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h803, 1'b1);
      checkOutput("trap vector aligned", fetchIf.fetch_pc, 32'h800);
`else
      checkOutput("unaligned target used", fetchIf.fetch_pc, 32'h102);
      expQ.push_back(32'h102);
      waitForPc(32'h106);
`endif

      // Reset in the middle of a waiting request with a redirect parked.
      applyStimulus(1'b0, 1'b1, 32'h300, 1'b0, 32'h0, 1'b0);
      checkOutput("pending before reset", 32'(redirectPending), 32'h1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("mid reset fetch_valid", 32'(fetchIf.fetch_valid), 32'h0);
      checkOutput("mid reset fetch_pc", fetchIf.fetch_pc, 32'h0);
      checkOutput("mid reset pending", 32'(redirectPending), 32'h0);
      @(posedge clk);
      #1;
      fetchIf.fetch_ready = 1'b1;
      rst = 1'b0;
      checkOutput("reboot fetch_valid", 32'(fetchIf.fetch_valid), 32'h0);
      expQ.push_back(32'h0);
      expQ.push_back(32'h4);
      waitForPc(32'h8);

      // Every expected transfer must have been consumed.
      fetchIf.fetch_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("scoreboard drained", 32'(expQ.size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised next-generation program counter and fetch-request generator.
- Holds the current fetch address and issues it to the instruction fetch stage over a valid/ready handshake.
- Sequences PC + INCR by default.
- Accepts branch/jump redirects and trap redirects with fixed priority, buffering one redirect that arrives while a request is waiting for acceptance.

Parameters:
- XLEN, 32, width of all address signals.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset (XLEN bits).
- INCR, 4, sequential increment in bytes.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  pipeline stall; blocks issue of new requests.
- redirect_valid  in  1  branch/jump redirect strobe, one cycle.
- redirect_target  in  XLEN  redirect address.
- trap_valid  in  1  trap redirect strobe, one cycle.
- trap_vector  in  XLEN  trap handler address.
- fetch_valid  out  1  fetch request valid.
- fetch_ready  in  1  fetch stage accepts request.
- fetch_pc  out  XLEN  address of current request (equals PC register).
- pc_plus_incr  out  XLEN  fetch_pc + INCR, combinational.
- redirect_pending  out  1  a buffered redirect is waiting.

Behaviour:
- Reset (async, rst=1):
  - PC = RESET_VECTOR; state = BOOT; fetch_valid = 0.
  - pending_valid = 0; pending_target = 0; redirect_pending = 0.
- States:
  - BOOT: fetch_valid = 0. Exactly one cycle after rst deasserts, then ISSUE if stall=0, else STALLED.
  - ISSUE: fetch_valid = 1.
  - STALLED: fetch_valid = 0.
- Handshake:
  - Transfer occurs when fetch_valid && fetch_ready.
  - While fetch_valid=1 and fetch_ready=0, fetch_pc and fetch_valid hold stable. Stall is ignored until the transfer completes.
- ISSUE with transfer:
  - PC <= next_pc.
  - Next state: STALLED if stall=1, else ISSUE.
  - Pending is cleared.
- next_pc priority: trap_valid ? trap_vector : redirect_valid ? redirect_target : pending_valid ? pending_target : PC + INCR.
- ISSUE without transfer:
  - trap_valid: pending <= trap_vector and is marked as a trap. It overwrites any existing pending entry.
  - redirect_valid (no trap): pending <= redirect_target, unless the pending entry is already a trap. A pending trap is never overwritten by a redirect.
  - Simultaneous trap and redirect: the trap wins.
- STALLED:
  - A trap or redirect updates PC directly (same priority) and clears pending.
  - stall=0: go to ISSUE next cycle; fetch_valid rises that cycle.
- BOOT: a redirect in this cycle loads PC directly (same as STALLED).
- Arithmetic: PC + INCR wraps modulo 2^XLEN; no overflow flag.
- redirect_pending = pending_valid (registered).
- Reset mid-handshake: everything returns to reset values immediately; the outstanding request is dropped.

Optional Feature:
- Macro PC_ALIGN_CHECK_EN.
- Defined:
  - Extra output misalign  out  1.
  - A redirect_target with bits [1:0] != 0 is not applied and not buffered. misalign pulses high for one cycle, the cycle after redirect_valid.
  - trap_vector is always applied with bits [1:0] forced to 0.
- Undefined:
  - No misalign port; targets are used unmodified.

Decomposition:
- Shared package: state enum encoding (BOOT, ISSUE, STALLED), default RESET_VECTOR constant, INCR default.
- Natural sub-module: pc_redirect_buf, a one-entry pending redirect register with trap-priority overwrite rule. Everything else stays in pc_gen.

Test Plan:
- Reset release, stall=0, fetch_ready=1 -> fetch_valid=0 for one cycle, then fetch_pc 0x0, 0x4, 0x8 on consecutive cycles.
- fetch_ready=0 for 3 cycles at PC 0x10 -> fetch_valid=1 and fetch_pc=0x10 held; on ready, next fetch_pc=0x14.
- fetch_ready=0 at PC 0x20, redirect to 0x100, then trap to 0x800 two cycles later, then ready -> redirect_pending=1; next fetch_pc=0x800, then 0x804.
- Same-cycle trap 0x800 and redirect 0x100 with ready=1 -> next fetch_pc=0x800.
- stall=1 after transfer at 0x40, redirect to 0x200 during stall, stall drop -> fetch_valid=0 while stalled; first request after stall is 0x200.
- PC=0xFFFF_FFFC, ready=1 -> next fetch_pc=0x0. With PC_ALIGN_CHECK_EN: redirect to 0x102 -> misalign pulse, sequence unchanged.
